// File: rtl/jvm_fetch_buffer.sv
// Bytecode prefetch: fetches 32-bit words, splits them big-endian into a byte FIFO, presents head byte to the translator.
// Build option FETCH_PREFETCH_EN: refill whenever 4 bytes are free; default refills only when the FIFO runs dry.
module jvm_fetch_buffer #(
  parameter int ADR_W = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [ADR_W-1:0] redirect_adr,
  input  logic             advance,
  output logic [7:0]       iram_data,
  output logic [ADR_W-1:0] byte_pc,
  output logic             waiting,
  output logic             mem_req,
  output logic [ADR_W-3:0] mem_adr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {STOP, FILL, BUSY, DRAIN} state_t;

  state_t           state_q;
  logic [7:0]       fifo_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic [ADR_W-3:0] fetch_word_q;
  logic [1:0]       skip_q;
  logic [ADR_W-1:0] byte_pc_q;
  logic [7:0]       iram_q;
  logic             waiting_q;
  logic             mem_req_q;
  logic [ADR_W-3:0] mem_adr_q;

  logic             pop, take, req_ok;
  logic [2:0]       push_n;
  logic [CW-1:0]    cnt_d, rem;
  logic [PW-1:0]    rd_nxt;
  logic [PW-1:0]    wr_idx [4];
  logic [7:0]       push_byte [4];
  logic [31:0]      shifted;
  logic [7:0]       head_d;
  logic [ADR_W-3:0] word_nxt;

  // Redirect has priority: it suppresses both the pop and the push of a coinciding ack.
  assign pop      = advance && (cnt_q != '0) && !redirect;
  assign take     = (state_q == BUSY) && mem_ack && !redirect;
  assign push_n   = take ? (3'd4 - {1'b0, skip_q}) : 3'd0;
  assign cnt_d    = redirect ? '0 : (cnt_q + CW'(push_n) - CW'(pop));
  assign rem      = cnt_q - CW'(pop);
  assign rd_nxt   = rd_q + {{(PW-1){1'b0}}, pop};
  assign word_nxt = fetch_word_q + {{(ADR_W-3){1'b0}}, 1'b1};
  assign shifted  = mem_data << {skip_q, 3'b000};

`ifdef FETCH_PREFETCH_EN
  assign req_ok = (cnt_d <= CW'(DEPTH - 4));
`else
  assign req_ok = (cnt_d == '0);
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      push_byte[k] = shifted[31-8*k -: 8];
      wr_idx[k]    = wr_q + PW'(k);
    end
    head_d = 8'h00;
    if (cnt_d != '0)
      head_d = (rem == '0) ? push_byte[0] : fifo_q[rd_nxt];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= STOP;
      mem_req_q    <= 1'b0;
      mem_adr_q    <= '0;
      fetch_word_q <= '0;
      skip_q       <= 2'd0;
    end else begin
      if (redirect) begin
        fetch_word_q <= redirect_adr[ADR_W-1:2];
        skip_q       <= redirect_adr[1:0];
      end
      case (state_q)
        STOP: if (redirect) state_q <= FILL;
        FILL: if (!redirect && req_ok) begin
          mem_req_q <= 1'b1;
          mem_adr_q <= fetch_word_q;
          state_q   <= BUSY;
        end
        BUSY: if (redirect) begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= FILL;
          end else begin
            state_q   <= DRAIN;
          end
        end else if (mem_ack) begin
          fetch_word_q <= word_nxt;
          skip_q       <= 2'd0;
          // Back-to-back request on the ack edge keeps a 1-cycle memory streaming.
          if (req_ok) begin
            mem_adr_q <= word_nxt;
          end else begin
            mem_req_q <= 1'b0;
            state_q   <= FILL;
          end
        end
        DRAIN: if (mem_ack) begin
          mem_req_q <= 1'b0;
          state_q   <= FILL;
        end
        default: state_q <= STOP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      byte_pc_q <= '0;
      iram_q    <= 8'h00;
      waiting_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      waiting_q <= (cnt_d == '0);
      iram_q    <= head_d;
      if (redirect) begin
        rd_q      <= '0;
        wr_q      <= '0;
        byte_pc_q <= redirect_adr;
      end else begin
        if (pop) begin
          rd_q      <= rd_nxt;
          byte_pc_q <= byte_pc_q + ADR_W'(1);
        end
        if (take) wr_q <= wr_q + PW'(push_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (take && (3'(k) < push_n)) fifo_q[wr_idx[k]] <= push_byte[k];
  end

  assign iram_data = iram_q;
  assign byte_pc   = byte_pc_q;
  assign waiting   = waiting_q;
  assign mem_req   = mem_req_q;
  assign mem_adr   = mem_adr_q;

endmodule

// File: doc/jvm_fetch_buffer.md
# jvm_fetch_buffer

Bytecode prefetch stage directly upstream of the JVM-to-ARM translator state machine. It fetches 32-bit words from JVM bytecode memory, splits them big-endian into bytes, and queues them in a small byte FIFO. It presents the head byte on `iram_data` with a `waiting` stall flag. The consumer pops bytes with `advance`, and branch handling restarts the stream with `redirect`.

## Interface
- `ADR_W`, 16: bytecode byte-address width.
- `DEPTH`, 8: FIFO depth in bytes; power of two, at least 8.
- `clk` input 1: single clock; all state updates on posedge.
- `reset` input 1: asynchronous, active-low reset.
- `redirect` input 1: one-cycle pulse; flush the stream and restart at `redirect_adr`.
- `redirect_adr` input ADR_W: byte address to restart at; may be unaligned.
- `advance` input 1: pop the head byte; ignored while `waiting`=1.
- `iram_data` output 8: head byte of FIFO; 0 when empty.
- `byte_pc` output ADR_W: byte address of `iram_data`.
- `waiting` output 1: 1 when no valid head byte.
- `mem_req` output 1: word read request.
- `mem_adr` output ADR_W-2: word address.
- `mem_ack` input 1: one-cycle pulse; `mem_data` is valid in the same cycle.
- `mem_data` input 32: word; byte 0 is `[31:24]`, byte 3 is `[7:0]`.

## Operation
- Reset values: `mem_req`=0, `mem_adr`=0, `iram_data`=0, `byte_pc`=0, `waiting`=1. FIFO count is 0. State is STOP.
- States:
  - STOP: after reset, no requests. On `redirect` go to FILL.
  - FILL: issue requests when allowed.
  - BUSY: request outstanding.
  - DRAIN: request outstanding, data to be discarded.
- Request rule: at most one outstanding request.
  - FILL raises `mem_req` when free space ≥ 4 and the prefetch condition holds (see Configuration).
  - `mem_req` and `mem_adr` are held stable until `mem_ack`, then go to FILL.
  - `mem_req` is deasserted the cycle after ack unless a new request is issued that same edge.
- Fetch address: `fetch_adr` is a byte address.
  - On `redirect`, `fetch_adr` = `redirect_adr`.
  - `mem_adr` = `fetch_adr[ADR_W-1:2]`.
  - On each accepted word, `fetch_adr` advances to the next word boundary.
- Unaligned start: the first word after a redirect pushes only bytes `redirect_adr[1:0]`..3. Later words push all 4 bytes.
- Pop: `advance` while `waiting`=0 removes the head byte and increments `byte_pc` by 1.
- `byte_pc` wraps modulo 2^ADR_W. `fetch_adr` wraps the same way; there is no error.
- Same-cycle push and pop: the new count is count + pushed − 1. The push never overflows because the space check was done at request time.
- Redirect:
  - FIFO count is cleared and `byte_pc` = `redirect_adr`.
  - If a request is outstanding, go to DRAIN: hold the request, discard its ack data, then go to FILL at the new address.
  - `redirect` coinciding with `advance` or `mem_ack`: the redirect wins. The pop is ignored and the ack data is discarded.
  - A second redirect while in DRAIN only updates the target.
- `waiting` = (count==0).

## Timing
- `waiting` and `iram_data` are registered. They reflect FIFO state after the current edge.
- A byte pushed by ack at edge N is visible at N+1 when the FIFO was empty.
- Redirect at edge N, aligned target, ack latency L: `mem_req` is high from N+1. The first byte is visible one cycle after the ack edge (N+1+L).
- Steady state: with prefetch enabled and memory latency 1, a consumer popping every cycle never sees `waiting`=1 after the initial fill.
- Reset asserted mid-transaction clears everything immediately. A late `mem_ack` after reset is ignored in STOP.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - FILL requests whenever free ≥ 4, so the FIFO stays topped up.
- `FETCH_PREFETCH_EN` not defined:
  - FILL requests only when count==0, or count==0 after the pop in the same cycle.
  - This gives lower memory traffic at the cost of a stall of at least L+1 cycles every 4 bytes.

## Test plan
- Reset, then redirect to 0x0010; memory returns 0x2A1B3C05 with latency 1.
  - Required: bytes 0x2A, 0x1B, 0x3C, 0x05 on consecutive pops.
  - Required: `byte_pc` 0x10..0x13; `waiting`=1 before the first byte.
- Redirect to 0x0013 (unaligned), word 0xAABBCCDD.
  - Required: only 0xDD is delivered, `byte_pc`=0x13.
  - Required: the next request is at `mem_adr`=0x0005.
- Redirect to 0x0040 while a request to word 0x04 is pending with ack delayed 3 cycles.
  - Required: the ack data is discarded and the next request is at `mem_adr`=0x0010.
- With prefetch enabled, DEPTH=8, consumer idle.
  - Required: FIFO fills to 8 bytes and `mem_req` stays low.
  - After 4 pops, exactly one new request is issued.
- Same cycle `advance`+`mem_ack` with count=1.
  - Required: count becomes 4 and the head byte is the word's byte 0.
  - Then `redirect`+`advance` in the same cycle: required `waiting`=1 next cycle and `byte_pc`=`redirect_adr`.
- Assert `reset` while `mem_req`=1.
  - Required: `mem_req`=0 and `waiting`=1 asynchronously.
  - A stray `mem_ack` afterwards pushes nothing.
